// File: rtl/led_frame_sched_pkg.sv
// Shared LED scheduler types: FSM state encoding, brightness type and default slot period.
package led_frame_sched_pkg;

    localparam int unsigned BRIGHT_W       = 5;
    localparam int unsigned DEF_PERIOD_CYC = 3000000;

    typedef logic [BRIGHT_W-1:0] bright_t;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } led_state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Frame slot counter: wraps every PERIOD_CYC cycles and pulses tick on the last count.
module led_tick_gen
    import led_frame_sched_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;

    always_comb begin
        cnt_n = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    // tick is registered alongside the count so it is high exactly while cnt_q == LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_n;
            tick  <= (cnt_n == LAST);
        end
    end

endmodule

// File: rtl/led_frame_sched.sv
// Paces LED frame updates to fixed slots and ramps SK9822 global brightness on en changes.
module led_frame_sched
    import led_frame_sched_pkg::*;
#(
    parameter int unsigned PERIOD_CYC    = DEF_PERIOD_CYC,
    parameter int unsigned MAX_BRIGHT    = 31,
    parameter int unsigned REFRESH_TICKS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                start_i,
    input  logic                busy_i,
    output logic                update_o,
    output logic                led_en_o,
    output logic [BRIGHT_W-1:0] bright_o,
    output logic [7:0]          overrun_cnt_o
);

    localparam int unsigned REF_W = $clog2(REFRESH_TICKS + 1);
    localparam bright_t     BMAX  = BRIGHT_W'(MAX_BRIGHT);

    logic             tick;
    led_state_e       state_q;
    led_state_e       state_n;
    bright_t          bright_n;
    logic             go_down;
    logic             pending_q;
    logic             deferred_q;
    logic [REF_W-1:0] refresh_q;
    logic             refresh_due;
    logic             ramping;
    logic             req_c;

    led_tick_gen #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Brightness FSM: state and brightness only move on slot ticks
    always_comb begin
        state_n  = state_q;
        bright_n = bright_o;
        go_down  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_OFF: begin
                    if (en) state_n = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (!en) begin
                        go_down = 1'b1;
                    end else if (bright_o < BMAX) begin
                        bright_n = bright_o + BRIGHT_W'(1);
                        if (bright_n == BMAX) state_n = ST_ON;
                    end else begin
                        state_n = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!en) go_down = 1'b1;
                end
                ST_RAMP_DOWN: begin
                    if (en) state_n = ST_RAMP_UP;
                    else    go_down = 1'b1;
                end
                default: state_n = ST_OFF;
            endcase
            if (go_down) begin
                if (bright_o > BRIGHT_W'(1)) begin
                    bright_n = bright_o - BRIGHT_W'(1);
                    state_n  = ST_RAMP_DOWN;
                end else begin
                    bright_n = '0;
                    state_n  = ST_OFF;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            bright_o <= '0;
            led_en_o <= 1'b0;
        end else begin
            state_q  <= state_n;
            bright_o <= bright_n;
            led_en_o <= (state_n != ST_OFF);
        end
    end

    // A ramp transition on either side of the tick changes brightness, so it always sends a frame
    always_comb begin
        refresh_due = (refresh_q >= REF_W'(REFRESH_TICKS - 1));
        ramping     = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN) ||
                      (state_n == ST_RAMP_UP) || (state_n == ST_RAMP_DOWN);
        req_c       = tick && (state_q != ST_OFF) && (pending_q || ramping || refresh_due);
    end

    // Update issue path: a single deferred slot; spacing guard keeps update_o from repeating back-to-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_o      <= 1'b0;
            pending_q     <= 1'b0;
            deferred_q    <= 1'b0;
            refresh_q     <= '0;
            overrun_cnt_o <= '0;
        end else begin
            update_o  <= 1'b0;
            pending_q <= start_i | (pending_q & ~update_o);

            if (tick && deferred_q && (overrun_cnt_o != 8'hFF)) begin
                overrun_cnt_o <= overrun_cnt_o + 8'd1;
            end

            if (deferred_q) begin
                if (!busy_i && !update_o) begin
                    update_o   <= 1'b1;
                    deferred_q <= 1'b0;
                end
            end else if (req_c) begin
                if (!busy_i && !update_o) update_o   <= 1'b1;
                else                      deferred_q <= 1'b1;
            end

            if (state_q == ST_OFF) begin
                refresh_q <= '0;
            end else if (tick) begin
                if (req_c)             refresh_q <= '0;
                else if (!refresh_due) refresh_q <= refresh_q + REF_W'(1);
            end
        end
    end

endmodule
